pe_mac_pipe: RTL
================

# pe_mac_pipe

Parametrised, pipelined successor to the systolic FP8 processing element. It accepts FP8 operands in either E4M3 or E5M2 format (per-element mode), forwards them systolically with a valid bit, and multiplies them. Products are accumulated in a signed, saturating fixed-point accumulator of configurable width. The block presents a registered BF16 view of the accumulator, plus sticky saturation and special-value flags. It is the tiling unit of the systolic array; neighbours chain through `a_out`/`b_out`/`valid_out`.

## Interface
- `ACC_W`, 24: accumulator width in bits, two's complement; legal range 16..32.
- `FRAC_BITS`, 10: fractional bits of the accumulator; legal range 6..`ACC_W`-8.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `clear` in 1: synchronous accumulator clear.
- `fmt` in 1: operand format of the current element; 0 = E4M3 (bias 7), 1 = E5M2 (bias 15).
- `in_valid` in 1: `a_in`/`b_in`/`fmt` carry a real element this cycle.
- `a_in`, `b_in` in 8: FP8 operands.
- `a_out`, `b_out` out 8: systolic pass-through of `a_in`/`b_in`, registered.
- `fmt_out`, `valid_out` out 1: pass-through of `fmt`/`in_valid`, registered.
- `c_out` out 16: BF16 image of the accumulator, registered.
- `c_valid` out 1: high when `c_out` reflects at least one accumulated element since the last clear.
- `sat_flag` out 1: sticky; set on any product or accumulation saturation.
- `nan_flag` out 1: sticky; set on any special operand (NaN or Inf).

## Operation
- **Pass-through.** Every cycle: `a_out<=a_in`, `b_out<=b_in`, `fmt_out<=fmt`, `valid_out<=in_valid`. This happens regardless of `clear`.
- **Decode.**
  - E4M3: exponent is bits[6:3]; mantissa is {hidden, m2, m1, m0}.
  - E5M2: exponent is bits[6:2]; mantissa is {hidden, m1, m0, 0}.
  - Hidden bit = (exponent != 0).
  - Unbiased exponent: for normals, exponent - bias; for denormals, 1 - bias (i.e. -6 or -14).
- **Special values.** E4M3 S.1111.111 is NaN. E5M2 with exponent 31 is Inf/NaN. A valid element with any special operand contributes 0 to the accumulator and sets `nan_flag`.
- **Stage 1 (S1) register.** Captured when `in_valid`:
  - sign = sa ^ sb;
  - 8-bit `mant_prod` = ma*mb, with 6 fractional bits;
  - signed 7-bit `exp_prod` = ea + eb (range -28..+30).
  - The S1 valid bit (`s1_v`) follows `in_valid`.
- **Stage 2 (S2) align.** Magnitude = `mant_prod` * 2^(`exp_prod`+`FRAC_BITS`-6).
  - Right shifts truncate toward zero; shifts that lose all bits yield 0.
  - If the magnitude exceeds MAX = 2^(`ACC_W`-1)-1, clamp it to MAX and set `sat_flag`.
- **Stage 2 (S2) accumulate** (when `s1_v`): `acc` ± magnitude, computed at `ACC_W`+1 bits, then clamped to [-MAX, +MAX]. Any clamp sets `sat_flag`. `c_valid` is set.
- **Clear.** When `clear` is high at an edge:
  - `acc`, `c_valid`, `sat_flag` and `nan_flag` go to 0, and `s1_v` is dropped (the in-flight product is discarded).
  - An element presented with `in_valid` in the same cycle is still captured into S1. It becomes the first term of the new sum.
- **BF16 conversion** (combinational from `acc`, then registered into `c_out`):
  - `acc` = 0 gives 0x0000.
  - Otherwise: sign = `acc` sign; p = leading-one position of |`acc`|; exponent = p - `FRAC_BITS` + 127; 7-bit mantissa = the bits below p, truncated (round toward zero, no rounding up).
  - The exponent is always in range for the legal parameter set.
- **No backpressure.** Every valid element is consumed.

## Timing
- **Reset** (`rst_n` low, asynchronous): all outputs and all internal registers are 0. This includes `c_out`=0x0000, `c_valid`=0, both flags 0, and `s1_v`=0. Reset mid-accumulation discards all state. The first edge after release behaves as after a clear.
- **Pass-through latency:** 1 cycle.
- **Result latency.** An element sampled at edge t:
  - is in S1 after t;
  - updates `acc` at t+1;
  - is visible on `c_out`/`c_valid`/flags at t+2.
- **Throughput:** one element per cycle, back-to-back, with no bubbles required.
- **Clear timing.**
  - Clear at edge t: `c_out` shows 0x0000 and `c_valid`=0 after t+1.
  - An element sampled at edge t-1 (in S1 at t) is lost.
  - An element sampled at edge t is kept.
- **Flags** are sticky from the edge of the offending accumulation until clear or reset.

## Test plan
- **Reset and simple accumulation.** Reset, then E4M3 0x38*0x38 (1.0*1.0) with `in_valid` for 1 cycle. Required: 2 cycles later `acc`=1024 (default parameters), `c_out`=0x3F80, `c_valid`=1, both flags 0. `a_out`=0x38 one cycle after input.
- **Back-to-back with sign.** 0x38*0x38, 0x40*0x38, 0xB8*0x38 on consecutive cycles (+1, +2, -1). Required: `c_out` sequence 0x3F80, 0x4040, 0x4000.
- **Mixed format.** E5M2 0x3C*0x3C (`fmt`=1) followed by E4M3 0x38*0x38. Required: final `c_out`=0x4000.
- **Saturation.** 0x7E*0x7E (448*448). Required: `acc`=0x7FFFFF, `sat_flag`=1, `c_out`=0x45FF. A subsequent -1.0 product leaves `sat_flag`=1.
- **Underflow and special values.**
  - 0x01*0x01 (2^-18): `acc` unchanged, `c_valid`=1.
  - E4M3 0x7F*0x38: `acc` unchanged, `nan_flag`=1.
- **Clear overlap and asynchronous reset.**
  - Valid 1.0*1.0 at edge t-1, then `clear`+valid 2.0*1.0 at edge t. Required: `c_out`=0x4000; the t-1 element is dropped.
  - Drop `rst_n` mid-cycle. Required: all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pe_mac_pipe.sv
// -----------------------------------------------------------------------------
// pe_mac_pipe : pipelined FP8 (E4M3 / E5M2) multiply-accumulate processing
// element for a systolic array.
//
// Operands are forwarded to the next PE one cycle later. Each valid element is
// multiplied in stage 1. In stage 2 the product is aligned to the signed
// fixed-point accumulator and added with saturation. The accumulator is
// presented as a registered BF16 value, alongside sticky saturation and
// special-value flags.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   clear               : synchronous accumulator / flag clear
//   fmt                 : operand format, 0 = E4M3 (bias 7), 1 = E5M2 (bias 15)
//   in_valid            : a_in / b_in / fmt carry a real element
//   a_in, b_in          : FP8 operands
//   a_out, b_out        : registered pass-through of a_in / b_in
//   fmt_out, valid_out  : registered pass-through of fmt / in_valid
//   c_out               : registered BF16 image of the accumulator
//   c_valid             : c_out reflects at least one element since last clear
//   sat_flag            : sticky, product or accumulation saturated
//   nan_flag            : sticky, a NaN / Inf operand was seen
// -----------------------------------------------------------------------------
module pe_mac_pipe #(
  parameter int ACC_W     = 24,
  parameter int FRAC_BITS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        fmt,
  input  logic        in_valid,
  input  logic [7:0]  a_in,
  input  logic [7:0]  b_in,
  output logic [7:0]  a_out,
  output logic [7:0]  b_out,
  output logic        fmt_out,
  output logic        valid_out,
  output logic [15:0] c_out,
  output logic        c_valid,
  output logic        sat_flag,
  output logic        nan_flag
);

  localparam int WIDE_W = ACC_W + 8;
  localparam logic [ACC_W-1:0]        MAX_MAG = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0]   MAX_EXT = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0]        ONE     = {{(ACC_W-1){1'b0}}, 1'b1};

  // Decoded FP8 operand: 4-bit mantissa with 3 fraction bits and a 6-bit
  // two's-complement unbiased exponent.
  typedef struct packed {
    logic       special;
    logic [3:0] mant;
    logic [5:0] exp;
  } fp8_t;

  function automatic fp8_t decode(input logic [7:0] v, input logic f);
    fp8_t       d;
    logic [4:0] e_eff;
    if (!f) begin
      d.special = (v[6:0] == 7'h7F);
      d.mant    = {(v[6:3] != 4'd0), v[2:0]};
      // Denormals use exponent field 1, giving 1 - bias.
      e_eff     = (v[6:3] == 4'd0) ? 5'd1 : {1'b0, v[6:3]};
      d.exp     = {1'b0, e_eff} - 6'd7;
    end else begin
      d.special = (v[6:2] == 5'h1F);
      d.mant    = {(v[6:2] != 5'd0), v[1:0], 1'b0};
      e_eff     = (v[6:2] == 5'd0) ? 5'd1 : v[6:2];
      d.exp     = {1'b0, e_eff} - 6'd15;
    end
    return d;
  endfunction

  fp8_t dec_a, dec_b;
  assign dec_a = decode(a_in, fmt);
  assign dec_b = decode(b_in, fmt);

  // ---------------------------------------------------------------------------
  // Pass-through and stage 1 (multiply)
  // ---------------------------------------------------------------------------
  logic              s1_v;
  logic              s1_sign;
  logic              s1_special;
  logic [7:0]        s1_mant;
  logic signed [6:0] s1_exp;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out      <= '0;
      b_out      <= '0;
      fmt_out    <= 1'b0;
      valid_out  <= 1'b0;
      s1_v       <= 1'b0;
      s1_sign    <= 1'b0;
      s1_special <= 1'b0;
      s1_mant    <= '0;
      s1_exp     <= '0;
    end else begin
      a_out     <= a_in;
      b_out     <= b_in;
      fmt_out   <= fmt;
      valid_out <= in_valid;
      // An element arriving with clear is still captured: it starts the new sum.
      s1_v      <= in_valid;
      if (in_valid) begin
        s1_sign    <= a_in[7] ^ b_in[7];
        s1_special <= dec_a.special | dec_b.special;
        s1_mant    <= 8'(dec_a.mant) * 8'(dec_b.mant);
        s1_exp     <= {dec_a.exp[5], dec_a.exp} + {dec_b.exp[5], dec_b.exp};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 (align + saturating accumulate)
  // ---------------------------------------------------------------------------
  int                       sh;
  logic [WIDE_W-1:0]        wide;
  logic                     prod_ovf;
  logic [ACC_W-1:0]         mag;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W:0]    acc_ext, mag_ext, sum, sum_c;
  logic                     acc_ovf;
  logic signed [ACC_W-1:0]  acc_next;

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    wide     = '0;
    prod_ovf = 1'b0;
    // mant_prod carries 6 fraction bits; the accumulator carries FRAC_BITS.
    sh       = int'(s1_exp) + FRAC_BITS - 6;
    if (sh >= 0) begin
      // Any nonzero mantissa shifted this far cannot fit below MAX.
      if (sh >= ACC_W) prod_ovf = (s1_mant != 8'd0);
      else             wide     = WIDE_W'(s1_mant) << sh;
    end else if (-sh < 8) begin
      wide = WIDE_W'(s1_mant) >> (-sh);
    end
    if (wide > {8'd0, MAX_MAG}) prod_ovf = 1'b1;
    mag = prod_ovf ? MAX_MAG : wide[ACC_W-1:0];

    acc_ext = {acc[ACC_W-1], acc};
    mag_ext = $signed({1'b0, mag});
    sum     = s1_sign ? (acc_ext - mag_ext) : (acc_ext + mag_ext);
    acc_ovf = 1'b0;
    sum_c   = sum;
    if (sum > MAX_EXT) begin
      sum_c   = MAX_EXT;
      acc_ovf = 1'b1;
    end else if (sum < -MAX_EXT) begin
      sum_c   = -MAX_EXT;
      acc_ovf = 1'b1;
    end
    acc_next = sum_c[ACC_W-1:0];
  end

  logic acc_v, sat_i, nan_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      acc_v <= 1'b0;
      sat_i <= 1'b0;
      nan_i <= 1'b0;
    end else if (clear) begin
      // The element sitting in S1 is discarded by not accumulating it.
      acc   <= '0;
      acc_v <= 1'b0;
      sat_i <= 1'b0;
      nan_i <= 1'b0;
    end else if (s1_v) begin
      acc_v <= 1'b1;
      if (s1_special) begin
        nan_i <= 1'b1;
      end else begin
        acc <= acc_next;
        if (prod_ovf || acc_ovf) sat_i <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // BF16 view of the accumulator (truncating), then output registers
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] abs_acc;
  int               lead;
  logic [7:0]       bf_exp;
  logic [6:0]       bf_mant;
  logic [15:0]      bf16;

  always_comb begin
    abs_acc = acc[ACC_W-1] ? (~acc + ONE) : acc;
    lead    = 0;
    for (int i = 0; i < ACC_W; i++) begin
      if (abs_acc[i]) lead = i;
    end
    bf_exp  = 8'(lead - FRAC_BITS + 127);
    // Bits lead-1 .. lead-7 land in positions 6..0; the leading one drops out.
    bf_mant = 7'({abs_acc, 7'd0} >> lead);
    bf16    = (abs_acc == '0) ? 16'h0000 : {acc[ACC_W-1], bf_exp, bf_mant};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_out    <= '0;
      c_valid  <= 1'b0;
      sat_flag <= 1'b0;
      nan_flag <= 1'b0;
    end else begin
      c_out    <= bf16;
      c_valid  <= acc_v;
      sat_flag <= sat_i;
      nan_flag <= nan_i;
    end
  end

endmodule
